// File: rtl/nyq_interp.sv
`default_nettype none
// ============================================================================
//  Module   : nyq_interp
//  Purpose  : Polyphase 32-tap FIR interpolator (1:8 upsample + low-pass).
//             One 24-bit signed sample is accepted per handshake. The block
//             then emits 8 filtered outputs, one per phase, on 8 consecutive
//             cycles. Coefficients are written over the shared parameter bus.
//  Ports    : Clk_CI    - clock, rising edge
//             Rst_RBI   - asynchronous active-low reset
//             WrEn_SI   - parameter write enable
//             Addr_DI   - parameter write address (words >= 32 are ignored)
//             PAR_In_DI - parameter write data, coefficient in [COEF_WIDTH-1:0]
//             In_DI     - input sample (signed)
//             Valid_SI  - In_DI valid
//             Ready_DO  - block can accept In_DI this cycle
//             Out_DO    - interpolated output sample (signed, registered)
//             Valid_DO  - Out_DO valid this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module nyq_interp #(
  parameter int ADDR_WIDTH = 9,
  parameter int MEM_WIDTH  = 32,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int COEF_WIDTH = 16,
  parameter int SHIFT      = 15
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]       Addr_DI,
  input  logic [MEM_WIDTH-1:0]        PAR_In_DI,
  input  logic signed [IN_WIDTH-1:0]  In_DI,
  input  logic                        Valid_SI,
  output logic                        Ready_DO,
  output logic signed [OUT_WIDTH-1:0] Out_DO,
  output logic                        Valid_DO
);

  localparam int NTAPS  = 32;
  localparam int TAP_AW = 5;
  localparam int ACC_W  = IN_WIDTH + COEF_WIDTH + 2;

  localparam logic signed [ACC_W-1:0] c_OUT_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_OUT_MIN =
    {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                        r_state;
  logic [2:0]                    r_phase;
  logic signed [COEF_WIDTH-1:0]  r_coef [NTAPS];
  logic signed [IN_WIDTH-1:0]    r_x    [4];
  logic signed [ACC_W-1:0]       r_acc;
  logic                          r_acc_vld;

  logic                          w_accept;
  logic                          w_coef_wr;
  logic signed [ACC_W-1:0]       w_acc;
  logic signed [ACC_W-1:0]       w_shift;
  logic signed [OUT_WIDTH-1:0]   w_sat;
  logic                          w_unused;

  // Only the coefficient slice of each parameter word is ever read back.
  assign w_unused = ^PAR_In_DI[MEM_WIDTH-1:COEF_WIDTH];

  // Ready in IDLE and on the last phase, so back-to-back samples run gapless.
  assign Ready_DO  = (r_state == S_IDLE) || (r_phase == 3'd7);
  assign w_accept  = Valid_SI && Ready_DO;
  // Addresses at or above the tap count are accepted on the bus but have no
  // observable effect, so they are not stored.
  assign w_coef_wr = WrEn_SI && ((Addr_DI >> TAP_AW) == '0);

  // Coefficient memory
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < NTAPS; i++) r_coef[i] <= '0;
    end else if (w_coef_wr) begin
      r_coef[Addr_DI[TAP_AW-1:0]] <= PAR_In_DI[COEF_WIDTH-1:0];
    end
  end

  // Control FSM and delay line
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= S_IDLE;
      r_phase <= 3'd0;
      for (int k = 0; k < 4; k++) r_x[k] <= '0;
    end else begin
      if (w_accept) begin
        r_x[3]  <= r_x[2];
        r_x[2]  <= r_x[1];
        r_x[1]  <= r_x[0];
        r_x[0]  <= In_DI;
        r_phase <= 3'd0;
        r_state <= S_RUN;
      end else if (r_state == S_RUN) begin
        if (r_phase == 3'd7) begin
          r_state <= S_IDLE;
          r_phase <= 3'd0;
        end else begin
          r_phase <= r_phase + 3'd1;
        end
      end
    end
  end

  // Phase p of the polyphase bank uses taps p, p+8, p+16, p+24.
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < 4; k++) begin
      w_acc = w_acc + ACC_W'(r_coef[{2'(k), r_phase}]) * ACC_W'(r_x[k]);
    end
  end

  // Accumulator stage: one register between the MAC and the output so that
  // the first output lands two edges after the accepting edge.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_acc     <= '0;
      r_acc_vld <= 1'b0;
    end else begin
      r_acc_vld <= (r_state == S_RUN);
      if (r_state == S_RUN) r_acc <= w_acc;
    end
  end

  assign w_shift = r_acc >>> SHIFT;

  always_comb begin
    w_sat = w_shift[OUT_WIDTH-1:0];
    if (w_shift > c_OUT_MAX)      w_sat = c_OUT_MAX[OUT_WIDTH-1:0];
    else if (w_shift < c_OUT_MIN) w_sat = c_OUT_MIN[OUT_WIDTH-1:0];
  end

  // Output register; holds the last sample while Valid_DO is low.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      Out_DO   <= '0;
      Valid_DO <= 1'b0;
    end else begin
      Valid_DO <= r_acc_vld;
      if (r_acc_vld) Out_DO <= w_sat;
    end
  end

endmodule
`default_nettype wire
